if_inst_queue: RTL and testbench
================================

// Module: if_inst_queue
// PURPOSE
//  Fetch-side instruction queue between IF (icache request/response) and pipeline_ID.
//  Buffers returned fetch packets (pc, inst, IF exception info, predictor fields) in a FIFO
//  and presents them to ID over the IF_ID_valid / ID_allowin handshake. Credit-based
//  issue control prevents overflow; a discard counter drops stale icache responses after a flush.
// PARAMETERS
//  DEPTH     4    queue entries; power of two, >= 2
//  ENTRY_WD  140  packet width; instantiated with `IF_TO_ID_WD
//  CNT_WD    3    occupancy/counter width; must hold DEPTH (clog2(DEPTH)+1)
// PORTS
//  clk            in   1         clock, all state updates on rising edge
//  reset          in   1         asynchronous, active-low reset
//  flush          in   1         exception | eret | refetch | wait flush, same OR as ID uses
//  req_issue      in   1         IF icache request accepted this cycle
//  req_allow      out  1         IF may issue a new request
//  resp_valid     in   1         icache returns one packet this cycle
//  resp_entry     in   ENTRY_WD  returned packet
//  ID_allowin     in   1         ID can accept a packet
//  IF_ID_valid    out  1         head packet valid toward ID
//  IF_to_ID_bus   out  ENTRY_WD  head packet
//  occupancy      out  CNT_WD    entries stored
//  overflow_err   out  1         sticky: push attempted when full
// BEHAVIOUR
//  - Reset (reset==0): rd/wr ptr=0, occupancy=0, outstanding=0, discard=0, overflow_err=0;
//    IF_ID_valid=0, IF_to_ID_bus=0, req_allow=1 (combinational from cleared state).
//  - outstanding: +1 on req_issue, -1 on any resp_valid (kept or dropped); both -> unchanged.
//  - req_allow = !flush && (occupancy + outstanding < DEPTH); computed at CNT_WD+1 bits.
//  - Push: resp_valid && discard==0 -> write resp_entry at wr_ptr, wr_ptr+1 mod DEPTH.
//  - Drop: resp_valid && discard!=0 -> entry ignored, discard-1.
//  - Pop: IF_ID_valid && ID_allowin -> rd_ptr+1 mod DEPTH. Pointers wrap naturally.
//  - IF_ID_valid = (occupancy!=0) && !flush; IF_to_ID_bus = mem[rd_ptr] (first-word fall-through),
//    forced to 0 when IF_ID_valid=0.
//  - Push+pop same cycle: occupancy unchanged; legal when full (pop frees slot first).
//  - Push when full and no pop: packet dropped, overflow_err set until reset. Cannot happen if
//    IF honours req_allow; verification treats it as an error.
//  - Flush cycle: pointers and occupancy cleared next edge; no pop; push suppressed;
//    discard <= outstanding_next (includes a req_issue in the flush cycle, minus a response
//    arriving in it). outstanding continues counting normally.
//  - Flush while discard!=0: discard reloaded from outstanding_next (no double count).
//  - Latency: resp_valid at edge N -> IF_ID_valid high after edge N (one cycle).
// CONFIGURATION
//  IF_QUEUE_BYPASS_EN defined: when occupancy==0, discard==0, !flush and resp_valid,
//    resp_entry drives IF_to_ID_bus with IF_ID_valid=1 in the same cycle; if ID_allowin,
//    packet consumed and not written (zero-latency); else written normally.
//  Undefined: no bypass; every packet spends at least one cycle in the queue.
// TESTING
//  1 reset low mid-traffic, occupancy=3 -> all outputs 0, req_allow=1 in same cycle, async.
//  2 issue 4 reqs, ID_allowin=0, 4 resps -> occupancy=4, req_allow=0; ID_allowin=1 -> 4 pops
//    in order, pc values A,A+4,A+8,A+C.
//  3 2 outstanding, 1 queued, flush -> occupancy=0, discard=2; next 2 resps dropped, 3rd
//    response pushed and presented.
//  4 full queue, resp_valid and ID_allowin same cycle (forced) -> occupancy stays 4,
//    overflow_err=0; same without ID_allowin -> overflow_err=1.
//  5 req_issue in flush cycle with 0 prior outstanding -> discard=1, that response dropped.
//  6 IF_QUEUE_BYPASS_EN, empty, resp_valid with ID_allowin=1 -> IF_ID_valid=1 same cycle,
//    occupancy stays 0; without macro -> valid next cycle.

Source files
------------

// File: rtl/if_inst_queue.sv
// Fetch-side instruction queue between the icache response path and ID.
// Ports: clk, reset (async, active-low), flush, req_issue/req_allow
// (issue credit), resp_valid/resp_entry (icache return), ID_allowin,
// IF_ID_valid/IF_to_ID_bus (head packet), occupancy, overflow_err.
// Optional macro IF_QUEUE_BYPASS_EN: an empty queue forwards a response
// to ID in the same cycle it arrives.
module if_inst_queue #(
    parameter int DEPTH    = 4,
    parameter int ENTRY_WD = 140,
    parameter int CNT_WD   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                req_issue,
    output logic                req_allow,
    input  logic                resp_valid,
    input  logic [ENTRY_WD-1:0] resp_entry,
    input  logic                ID_allowin,
    output logic                IF_ID_valid,
    output logic [ENTRY_WD-1:0] IF_to_ID_bus,
    output logic [CNT_WD-1:0]   occupancy,
    output logic                overflow_err
);

    localparam int PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_WD-1:0] mem_q [DEPTH];
    logic [PTR_WD-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_WD-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_WD-1:0]   occ_q, occ_d;
    logic [CNT_WD-1:0]   outst_q, outst_d;
    logic [CNT_WD-1:0]   disc_q, disc_d;
    logic                ovf_q, ovf_d;

    logic                empty, full, disc_zero;
    logic                head_valid, q_pop;
    logic                push_req, do_push;
    logic                byp_valid, byp_take;
    logic [CNT_WD:0]     inflight;

    assign empty      = (occ_q == '0);
    assign full       = (occ_q == CNT_WD'(DEPTH));
    assign disc_zero  = (disc_q == '0);
    assign head_valid = !empty && !flush;
    assign q_pop      = head_valid && ID_allowin;
    assign push_req   = resp_valid && disc_zero && !flush;

`ifdef IF_QUEUE_BYPASS_EN
    assign byp_valid = empty && disc_zero && !flush && resp_valid;
`else
    assign byp_valid = 1'b0;
`endif

    // A bypassed packet that ID takes this cycle never enters storage.
    assign byp_take = byp_valid && ID_allowin;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign do_push  = push_req && !byp_take && (!full || q_pop);

    // Credits: stored entries plus requests still owed a response.
    assign inflight  = {1'b0, occ_q} + {1'b0, outst_q};
    assign req_allow = !flush && (inflight < (CNT_WD+1)'(DEPTH));

    assign IF_ID_valid  = head_valid || byp_valid;
    assign occupancy    = occ_q;
    assign overflow_err = ovf_q;

    always_comb begin
        IF_to_ID_bus = '0;
        if (head_valid) begin
            IF_to_ID_bus = mem_q[rd_ptr_q];
        end else if (byp_valid) begin
            IF_to_ID_bus = resp_entry;
        end
    end

    // Outstanding counts every response, kept or dropped.
    assign outst_d = outst_q + CNT_WD'(req_issue) - CNT_WD'(resp_valid);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        disc_d   = disc_q;
        ovf_d    = ovf_q | (push_req && full && !q_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
            // Every response still owed after this edge is stale.
            disc_d   = outst_d;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_WD'(1);
            if (q_pop)   rd_ptr_d = rd_ptr_q + PTR_WD'(1);
            if (do_push && !q_pop) begin
                occ_d = occ_q + CNT_WD'(1);
            end else if (!do_push && q_pop) begin
                occ_d = occ_q - CNT_WD'(1);
            end
            if (resp_valid && !disc_zero) begin
                disc_d = disc_q - CNT_WD'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            outst_q  <= '0;
            disc_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            outst_q  <= outst_d;
            disc_q   <= disc_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; reads are masked by occupancy.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= resp_entry;
        end
    end

endmodule

// File: tb/tb_if_inst_queue.sv
// Bench for if_inst_queue: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_if_inst_queue;

    localparam int DEPTH = 4;
    localparam int EW    = 140;
    localparam int CW    = 3;

`ifdef IF_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          req_issue = 1'b0;
    logic          resp_valid = 1'b0;
    logic [EW-1:0] resp_entry = '0;
    logic          ID_allowin = 1'b0;
    logic          req_allow;
    logic          IF_ID_valid;
    logic [EW-1:0] IF_to_ID_bus;
    logic [CW-1:0] occupancy;
    logic          overflow_err;

    int total = 0;
    int bad   = 0;

    if_inst_queue #(.DEPTH(DEPTH), .ENTRY_WD(EW), .CNT_WD(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .req_issue    (req_issue),
        .req_allow    (req_allow),
        .resp_valid   (resp_valid),
        .resp_entry   (resp_entry),
        .ID_allowin   (ID_allowin),
        .IF_ID_valid  (IF_ID_valid),
        .IF_to_ID_bus (IF_to_ID_bus),
        .occupancy    (occupancy),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] mk(input logic [31:0] pc);
        return {~pc, 76'h0, pc};
    endfunction

    task automatic chk(input string nm, input logic [EW-1:0] got,
                       input logic [EW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a plain queue of packets plus two counters.
    logic [EW-1:0] mq[$];
    logic [EW-1:0] nq[$];
    int  m_out = 0, m_disc = 0, n_out, n_disc;
    bit  m_ovf = 0, n_ovf;

    initial begin : compare
        bit            byp, e_valid, e_allow, taken;
        logic [EW-1:0] e_bus;
        forever begin
            @(negedge clk);
            #3;
            if (!reset) begin
                mq.delete();
                m_out  = 0;
                m_disc = 0;
                m_ovf  = 0;
            end
            byp = BYP && mq.size() == 0 && m_disc == 0 && !flush && resp_valid;
            e_valid = !flush && (mq.size() > 0 || byp);
            e_bus = '0;
            if (e_valid) e_bus = (mq.size() > 0) ? mq[0] : resp_entry;
            e_allow = !flush && (mq.size() + m_out < DEPTH);
            chk("m_valid", {139'b0, IF_ID_valid}, {139'b0, e_valid});
            chk("m_bus", IF_to_ID_bus, e_bus);
            chk("m_allow", {139'b0, req_allow}, {139'b0, e_allow});
            chk("m_occ", EW'(occupancy), EW'(mq.size()));
            chk("m_ovf", {139'b0, overflow_err}, {139'b0, m_ovf});

            n_out  = m_out + int'(req_issue) - int'(resp_valid);
            nq     = mq;
            n_disc = m_disc;
            n_ovf  = m_ovf;
            if (flush) begin
                nq.delete();
                n_disc = n_out;
            end else begin
                taken = e_valid && ID_allowin;
                if (taken && mq.size() > 0) void'(nq.pop_front());
                if (resp_valid) begin
                    if (m_disc > 0) n_disc--;
                    else if (!(taken && mq.size() == 0)) begin
                        if (nq.size() < DEPTH) nq.push_back(resp_entry);
                        else n_ovf = 1;
                    end
                end
            end
            @(posedge clk);
            if (reset) begin
                mq     = nq;
                m_out  = n_out;
                m_disc = n_disc;
                m_ovf  = n_ovf;
            end
        end
    end

    task automatic cyc(input logic iss, input logic rv, input logic [31:0] pc,
                       input logic al, input logic fl);
        @(negedge clk);
        req_issue  = iss;
        resp_valid = rv;
        resp_entry = rv ? mk(pc) : '0;
        ID_allowin = al;
        flush      = fl;
        #2;
    endtask

    task automatic idle();
        cyc(0, 0, 32'h0, 0, 0);
    endtask

    initial begin : drive
        logic [31:0] a;
        a = 32'h1000;
        idle();
        idle();
        chk("rst_occ", EW'(occupancy), EW'(0));
        chk("rst_allow", EW'(req_allow), EW'(1));
        chk("rst_valid", EW'(IF_ID_valid), EW'(0));
        chk("rst_bus", IF_to_ID_bus, '0);
        @(negedge clk);
        reset = 1'b1;

        // Fill to depth with ID stalled, then drain in order.
        for (int i = 0; i < 4; i++) cyc(1, 0, 32'h0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, a + 32'(4 * i), 0, 0);
        idle();
        chk("t2_occ", EW'(occupancy), EW'(4));
        chk("t2_allow", EW'(req_allow), EW'(0));
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 32'h0, 1, 0);
            chk("t2_pc", EW'(IF_to_ID_bus[31:0]), EW'(a + 32'(4 * i)));
        end
        idle();
        chk("t2_empty", EW'(occupancy), EW'(0));

        // Flush with 2 outstanding and 1 queued.
        for (int i = 0; i < 3; i++) cyc(1, 0, 32'h0, 0, 0);
        cyc(0, 1, 32'h1100, 0, 0);
        cyc(0, 0, 32'h0, 0, 1);
        chk("t3_fvalid", EW'(IF_ID_valid), EW'(0));
        cyc(0, 1, 32'hdead0, 0, 0);
        chk("t3_occ0", EW'(occupancy), EW'(0));
        cyc(0, 1, 32'hdead4, 0, 0);
        cyc(1, 0, 32'h0, 0, 0);
        chk("t3_drop", EW'(occupancy), EW'(0));
        cyc(0, 1, 32'h1200, 0, 0);
        cyc(0, 0, 32'h0, 1, 0);
        chk("t3_keep", EW'(IF_to_ID_bus[31:0]), EW'(32'h1200));
        idle();

        // Full queue with forced responses.
        for (int i = 0; i < 4; i++) cyc(1, 0, 32'h0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'h2000 + 32'(4 * i), 0, 0);
        cyc(1, 1, 32'h3000, 1, 0);
        cyc(0, 0, 32'h0, 0, 0);
        chk("t4_occ", EW'(occupancy), EW'(4));
        chk("t4_noerr", EW'(overflow_err), EW'(0));
        chk("t4_head", EW'(IF_to_ID_bus[31:0]), EW'(32'h2004));
        cyc(1, 1, 32'h4000, 0, 0);
        idle();
        chk("t4_err", EW'(overflow_err), EW'(1));
        for (int i = 0; i < 4; i++) cyc(0, 0, 32'h0, 1, 0);
        idle();
        chk("t4_drain", EW'(occupancy), EW'(0));

        // Request issued in the flush cycle itself.
        cyc(1, 0, 32'h0, 0, 1);
        cyc(0, 1, 32'h5555, 0, 0);
        idle();
        chk("t5_drop", EW'(occupancy), EW'(0));
        chk("t5_valid", EW'(IF_ID_valid), EW'(0));

        // Empty queue, response with ID ready.
        cyc(1, 0, 32'h0, 0, 0);
        cyc(0, 1, 32'h6000, 1, 0);
        if (BYP) begin
            chk("t6_bvalid", EW'(IF_ID_valid), EW'(1));
            chk("t6_bbus", EW'(IF_to_ID_bus[31:0]), EW'(32'h6000));
        end else begin
            chk("t6_nvalid", EW'(IF_ID_valid), EW'(0));
        end
        cyc(0, 0, 32'h0, 1, 0);
        chk("t6_occ", EW'(occupancy), BYP ? EW'(0) : EW'(1));
        idle();

        // Async reset mid-traffic with 3 entries queued.
        for (int i = 0; i < 3; i++) cyc(1, 0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h7000 + 32'(4 * i), 0, 0);
        idle();
        chk("t1_pre", EW'(occupancy), EW'(3));
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("t1_occ", EW'(occupancy), EW'(0));
        chk("t1_valid", EW'(IF_ID_valid), EW'(0));
        chk("t1_bus", IF_to_ID_bus, '0);
        chk("t1_allow", EW'(req_allow), EW'(1));
        chk("t1_ovf", EW'(overflow_err), EW'(0));
        @(negedge clk);
        reset = 1'b1;
        idle();
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
